// File: rtl/johnson_seq_ctrl.sv
// rtl/johnson_seq_ctrl.sv - Johnson counter sequencing controller
// Runs a WIDTH-stage twisted-ring counter for a programmed number of rotations.
module johnson_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int LOOP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [LOOP_W-1:0]  loops,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t            state, state_n;
  logic [LOOP_W-1:0] remaining, remaining_n;
  logic [WIDTH-1:0]  q_n, adv;
  logic              wrap_n, err_n, legal;

  // k-th code of the sequence: k low ones filling up, then zeros filling from the bottom
  function automatic logic [WIDTH-1:0] code(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
    return c;
  endfunction

  always_comb begin
    phase = '0;
    for (int k = 0; k < 2*WIDTH; k++)
      if (q == code(k)) phase[k] = 1'b1;
  end

  assign legal = |phase;
  assign adv   = {q[WIDTH-2:0], ~q[WIDTH-1]};
  assign busy  = (state == RUN) || (state == HOLD);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      remaining <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      remaining <= remaining_n;
      wrap      <= wrap_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    remaining_n = remaining;
    wrap_n      = 1'b0;
    err_n       = err;
    if (!legal) begin
      err_n   = 1'b1;
      q_n     = '0;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state_n     = RUN;
            remaining_n = loops;
          end
        end
        RUN, HOLD: begin
          if (abort) begin
            state_n = IDLE;
            q_n     = '0;
          end else if (pause) begin
            state_n = HOLD;
          end else begin
            // Leaving HOLD advances on the same edge, so a pause of k cycles delays by k
            state_n = RUN;
            q_n     = adv;
            if (adv == '0) begin
              wrap_n = 1'b1;
              // remaining==0 means a free-running (loops==0) session
              if (remaining == LOOP_W'(1))
                state_n = DONE;
              else if (remaining != '0)
                remaining_n = remaining - LOOP_W'(1);
            end
          end
        end
        DONE: begin
          state_n = IDLE;
          q_n     = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb/tb_johnson_seq_ctrl.sv - self-checking bench for johnson_seq_ctrl
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [7:0] loops;
  logic [3:0] q;
  logic [7:0] phase;
  logic       busy, wrap, done, err;

  int total = 0;
  int bad   = 0;

  johnson_seq_ctrl #(.WIDTH(4), .LOOP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .loops(loops), .q(q), .phase(phase), .busy(busy), .wrap(wrap),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, pause, abort;
    logic [7:0] loops;
    logic [3:0] q;
    logic [7:0] phase;
    logic       busy, wrap, done;
  } vec_t;

  vec_t       vecs[20];
  logic [3:0] jseq[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int pos;
    jseq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    // loops=1 full rotation
    vecs[0]  = '{1, 0, 0, 8'd1, 4'h0, 8'h01, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 8'd0, 4'h1, 8'h02, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 8'd0, 4'h3, 8'h04, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 8'd0, 4'h7, 8'h08, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 8'd0, 4'hF, 8'h10, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 8'd0, 4'hE, 8'h20, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 8'd0, 4'hC, 8'h40, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 8'd0, 4'h8, 8'h80, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 8'd0, 4'h0, 8'h01, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 8'd0, 4'h0, 8'h01, 0, 0, 0};
    // abort together with start in IDLE
    vecs[10] = '{1, 0, 1, 8'd1, 4'h0, 8'h01, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 8'd1, 4'h0, 8'h01, 0, 0, 0};
    // abort at q=E
    vecs[12] = '{1, 0, 0, 8'd1, 4'h0, 8'h01, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 8'd0, 4'h1, 8'h02, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 8'd0, 4'h3, 8'h04, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 8'd0, 4'h7, 8'h08, 1, 0, 0};
    vecs[16] = '{0, 0, 0, 8'd0, 4'hF, 8'h10, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 8'd0, 4'hE, 8'h20, 1, 0, 0};
    vecs[18] = '{0, 0, 1, 8'd0, 4'h0, 8'h01, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 8'd0, 4'h0, 8'h01, 0, 0, 0};

    // reset with start held high
    reset = 1; start = 1; pause = 0; abort = 0; loops = 8'd1;
    tick(); tick();
    chk("rst_q", q, 4'h0);
    chk("rst_phase", phase, 8'h01);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 0; start = 0;
    tick();
    chk("post_rst_idle", busy, 0);

    for (int i = 0; i < 20; i++) begin
      start = vecs[i].start; pause = vecs[i].pause;
      abort = vecs[i].abort; loops = vecs[i].loops;
      tick();
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_phase", i), phase, vecs[i].phase);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_wrap", i), wrap, vecs[i].wrap);
      chk($sformatf("v%0d_done", i), done, vecs[i].done);
    end
    start = 0; abort = 0;

    // loops=2: wrap at 8 and 16, done only at 16
    start = 1; loops = 8'd2;
    tick();
    start = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("l2_q_c%0d", c), q, jseq[c % 8]);
      chk($sformatf("l2_wrap_c%0d", c), wrap, (c % 8) == 0);
      chk($sformatf("l2_done_c%0d", c), done, c == 16);
      chk($sformatf("l2_busy_c%0d", c), busy, c < 16);
    end
    tick();

    // loops=0: free-running, wrap every 8, never done
    start = 1; loops = 8'd0;
    tick();
    start = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk($sformatf("l0_wrap_c%0d", c), wrap, (c % 8) == 0);
      chk($sformatf("l0_done_c%0d", c), done, 0);
      chk($sformatf("l0_busy_c%0d", c), busy, 1);
    end
    abort = 1;
    tick();
    abort = 0;
    chk("l0_abort_busy", busy, 0);
    chk("l0_abort_q", q, 4'h0);

    // pause for 3 cycles while q=7: done moves from cycle 8 to 11
    start = 1; loops = 8'd1;
    tick();
    start = 0;
    pos = 0;
    for (int c = 1; c <= 11; c++) begin
      pause = (c >= 4) && (c <= 6);
      tick();
      if (!pause) pos++;
      chk($sformatf("pz_q_c%0d", c), q, jseq[pos % 8]);
      chk($sformatf("pz_busy_c%0d", c), busy, pos < 8);
      chk($sformatf("pz_done_c%0d", c), done, c == 11);
    end
    pause = 0;
    tick();

    // start pulse mid-run at q=3 is ignored
    start = 1; loops = 8'd1;
    tick();
    start = 0;
    for (int c = 1; c <= 8; c++) begin
      start = (c == 3);
      loops = (c == 3) ? 8'd5 : 8'd1;
      tick();
      chk($sformatf("ms_q_c%0d", c), q, jseq[c % 8]);
      chk($sformatf("ms_done_c%0d", c), done, c == 8);
    end
    start = 0;
    tick();
    chk("ms_no_restart", busy, 0);

    // illegal code upset during a run
    start = 1; loops = 8'd0;
    tick();
    start = 0;
    tick(); tick();
    force dut.q = 4'h5;
    tick();
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    release dut.q;
    tick();
    chk("ill_q", q, 4'h0);
    chk("ill_err_sticky", err, 1);
    tick();
    chk("ill_err_sticky2", err, 1);
    chk("ill_done", done, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("ill_err_clear", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
